// File: rtl/wave_trigger_writer.sv
// Write side of the double-buffered 512x8 waveform RAM.
// Waits for a rising zero crossing (or an auto-trigger timeout), captures 256
// decimated offset-binary samples into the half the display is not reading,
// then flips read_index during display idle so the fresh capture is shown.
//
// Handshake: new_sample_ready is a one-cycle strobe with no back-pressure;
// new_sample_in is valid only in a cycle where the strobe is high, and every
// strobe is consumed in that cycle. write_enable is a one-cycle strobe with
// write_address/write_sample valid in the same cycle, one cycle after the
// strobe that produced it.
module wave_trigger_writer #(
    parameter int unsigned DECIMATE     = 1,     // 1..16
    parameter int unsigned AUTO_TIMEOUT = 1024   // 0 disables auto-trigger
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index,
    output logic        armed,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [4:0]  DEC_LAST = 5'(DECIMATE);
    localparam logic [15:0] TO_LIMIT = 16'(AUTO_TIMEOUT);
    localparam bit          TO_EN    = (AUTO_TIMEOUT != 0);
    localparam logic [7:0]  IDX_LAST = 8'd255;

    state_t      state_q,        state_d;
    logic        prev_sign_q,    prev_sign_d;
    logic [7:0]  index_q,        index_d;
    logic [4:0]  dec_cnt_q,      dec_cnt_d;
    logic [15:0] to_cnt_q,       to_cnt_d;
    logic        read_index_q,   read_index_d;
    logic        armed_q,        armed_d;
    logic        we_q,           we_d;
    logic [8:0]  waddr_q,        waddr_d;
    logic [7:0]  wsample_q,      wsample_d;

    logic        sign_now;
    logic        crossing;
    logic        timeout_hit;
    logic [7:0]  sample_ob;
    logic [15:0] to_inc;
    logic [4:0]  dec_inc;
    logic [7:0]  idx_inc;
    logic        sample_lsbs_unused;

    // Only the top byte of each sample is stored; the low byte is dropped.
    assign sample_lsbs_unused = ^new_sample_in[7:0];

    // Per-strobe helper terms: crossing detect, offset-binary conversion, counters.
    always_comb begin
        sign_now    = new_sample_in[15];
        crossing    = prev_sign_q & ~sign_now;
        sample_ob   = {~new_sample_in[15], new_sample_in[14:8]};
        to_inc      = to_cnt_q + 16'd1;
        dec_inc     = dec_cnt_q + 5'd1;
        idx_inc     = index_q + 8'd1;
        timeout_hit = TO_EN && (to_inc == TO_LIMIT);
    end

    // Next-state and registered-output logic for the capture FSM.
    always_comb begin
        state_d      = state_q;
        prev_sign_d  = prev_sign_q;
        index_d      = index_q;
        dec_cnt_d    = dec_cnt_q;
        to_cnt_d     = to_cnt_q;
        read_index_d = read_index_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wsample_d    = wsample_q;

        // The sign history tracks every strobe, regardless of state.
        if (new_sample_ready) begin
            prev_sign_d = sign_now;
        end

        case (state_q)
            ST_ARMED: begin
                if (new_sample_ready) begin
                    if (crossing || timeout_hit) begin
                        // Trigger: the triggering sample itself is index 0.
                        we_d      = 1'b1;
                        waddr_d   = {~read_index_q, 8'd0};
                        wsample_d = sample_ob;
                        index_d   = 8'd0;
                        dec_cnt_d = 5'd0;
                        to_cnt_d  = 16'd0;
                        state_d   = ST_ACTIVE;
                    end else begin
                        to_cnt_d = to_inc;
                    end
                end
            end

            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    if (dec_inc == DEC_LAST) begin
                        dec_cnt_d = 5'd0;
                        we_d      = 1'b1;
                        waddr_d   = {~read_index_q, idx_inc};
                        wsample_d = sample_ob;
                        if (idx_inc == IDX_LAST) begin
                            // Capture complete; index wraps ready for the next one.
                            index_d = 8'd0;
                            state_d = ST_WAIT;
                        end else begin
                            index_d = idx_inc;
                        end
                    end else begin
                        dec_cnt_d = dec_inc;
                    end
                end
            end

            ST_WAIT: begin
                // Flip the display half only while it is not being read.
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ST_ARMED;
                end
            end

            default: begin
                state_d = ST_ARMED;
            end
        endcase

        armed_d = (state_d == ST_ARMED);
    end

    // State and output registers; reset abandons any capture in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARMED;
            prev_sign_q  <= 1'b0;
            index_q      <= 8'd0;
            dec_cnt_q    <= 5'd0;
            to_cnt_q     <= 16'd0;
            read_index_q <= 1'b0;
            armed_q      <= 1'b1;
            we_q         <= 1'b0;
            waddr_q      <= 9'd0;
            wsample_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_sign_q  <= prev_sign_d;
            index_q      <= index_d;
            dec_cnt_q    <= dec_cnt_d;
            to_cnt_q     <= to_cnt_d;
            read_index_q <= read_index_d;
            armed_q      <= armed_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wsample_q    <= wsample_d;
        end
    end

    assign write_address = waddr_q;
    assign write_enable  = we_q;
    assign write_sample  = wsample_q;
    assign read_index    = read_index_q;
    assign armed         = armed_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_wave_trigger_writer.sv
// Bench for wave_trigger_writer: three instances with different DECIMATE /
// AUTO_TIMEOUT settings, directed stimulus, scoreboard of expected RAM writes.
module tb_wave_trigger_writer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  reset;
    logic [2:0]  strobe;
    logic [2:0]  idle;
    logic [15:0] din   [3];
    logic [8:0]  waddr [3];
    logic [7:0]  wsamp [3];
    logic [1:0]  dbg   [3];
    logic [2:0]  we;
    logic [2:0]  ridx;
    logic [2:0]  armed;

    localparam logic [1:0] S_ARMED  = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    // Instance 0: DECIMATE=1, AUTO_TIMEOUT=1024
    wave_trigger_writer #(.DECIMATE(1), .AUTO_TIMEOUT(1024)) dut_a (
        .clk(clk), .reset(reset[0]), .new_sample_ready(strobe[0]),
        .new_sample_in(din[0]), .wave_display_idle(idle[0]),
        .write_address(waddr[0]), .write_enable(we[0]), .write_sample(wsamp[0]),
        .read_index(ridx[0]), .armed(armed[0]), .dbg_state(dbg[0])
    );

    // Instance 1: DECIMATE=4, auto-trigger disabled
    wave_trigger_writer #(.DECIMATE(4), .AUTO_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset[1]), .new_sample_ready(strobe[1]),
        .new_sample_in(din[1]), .wave_display_idle(idle[1]),
        .write_address(waddr[1]), .write_enable(we[1]), .write_sample(wsamp[1]),
        .read_index(ridx[1]), .armed(armed[1]), .dbg_state(dbg[1])
    );

    // Instance 2: DECIMATE=1, AUTO_TIMEOUT=16
    wave_trigger_writer #(.DECIMATE(1), .AUTO_TIMEOUT(16)) dut_c (
        .clk(clk), .reset(reset[2]), .new_sample_ready(strobe[2]),
        .new_sample_in(din[2]), .wave_display_idle(idle[2]),
        .write_address(waddr[2]), .write_enable(we[2]), .write_sample(wsamp[2]),
        .read_index(ridx[2]), .armed(armed[2]), .dbg_state(dbg[2])
    );

    // ---------------- scoreboard ----------------
    // Entry = {instance[1:0], address[8:0], sample[7:0]}
    logic [18:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt [3] = '{0, 0, 0};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every write strobe is matched against the head of the queue.
    logic [18:0] exp_e;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (we[k] === 1'b1) begin
                wr_cnt[k]++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: dut %0d wrote addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                             k, waddr[k], wsamp[k], $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("write", {13'd0, k[1:0], waddr[k], wsamp[k]}, {13'd0, exp_e});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int k, input logic [15:0] v);
        @(negedge clk);
        strobe[k] = 1'b1;
        din[k]    = v;
        @(negedge clk);
        strobe[k] = 1'b0;
        #1;
    endtask

    task automatic send_exp(input int k, input logic [15:0] v,
                            input logic [8:0] a, input logic [7:0] s);
        exp_q.push_back({k[1:0], a, s});
        send(k, v);
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk);
        reset[k] = 1'b1;
        @(negedge clk);
        reset[k] = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_we",    {31'd0, we[k]},    32'd0);
        check("rst_addr",  {23'd0, waddr[k]}, 32'd0);
        check("rst_samp",  {24'd0, wsamp[k]}, 32'd0);
        check("rst_ridx",  {31'd0, ridx[k]},  32'd0);
        check("rst_armed", {31'd0, armed[k]}, 32'd1);
        check("rst_state", {30'd0, dbg[k]},   {30'd0, S_ARMED});
    endtask

    // Watchdog: the stimulus is straight-line, this only guards against a stuck sim.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int base;
    initial begin
        reset  = 3'b111;
        strobe = 3'b000;
        idle   = 3'b000;
        for (int k = 0; k < 3; k++) din[k] = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) check_reset_outputs(k);

        // 1: positive samples, no crossing
        send(0, 16'h0100);
        send(0, 16'h7FFF);
        check("t1_no_write", wr_cnt[0], 0);
        check("t1_armed",    {31'd0, armed[0]}, 32'd1);
        check("t1_ridx",     {31'd0, ridx[0]},  32'd0);

        // 2: crossing capture into upper half, 256 writes then WAIT
        send(0, 16'hFFFB);
        send_exp(0, 16'h1234, 9'h100, 8'h92);
        check("t2_armed_low", {31'd0, armed[0]}, 32'd0);
        check("t2_active",    {30'd0, dbg[0]},   {30'd0, S_ACTIVE});
        for (int i = 1; i < 256; i++)
            send_exp(0, 16'h8000, {1'b1, 8'(i)}, 8'h00);
        check("t2_wait", {30'd0, dbg[0]}, {30'd0, S_WAIT});
        send(0, 16'h8000);
        check("t2_257th_no_write", wr_cnt[0], 256);

        // 3: WAIT holds until display idle, then flip and re-arm
        repeat (10) send(0, 16'h8000);
        check("t3_wait_no_write", wr_cnt[0], 256);
        check("t3_ridx_hold",     {31'd0, ridx[0]},  32'd0);
        check("t3_armed_low",     {31'd0, armed[0]}, 32'd0);
        @(negedge clk);
        idle[0] = 1'b1;
        @(negedge clk);
        #1;
        check("t3_ridx_flip", {31'd0, ridx[0]},  32'd1);
        check("t3_armed",     {31'd0, armed[0]}, 32'd1);
        check("t3_state",     {30'd0, dbg[0]},   {30'd0, S_ARMED});
        idle[0] = 1'b0;
        send(0, 16'hFF00);
        send_exp(0, 16'h0000, 9'h000, 8'h80);

        // 6: capture into lower half up to index 100, then reset with a strobe
        for (int i = 1; i <= 100; i++)
            send_exp(0, 16'h0000, {1'b0, 8'(i)}, 8'h80);
        @(negedge clk);
        reset[0]  = 1'b1;
        strobe[0] = 1'b1;
        din[0]    = 16'h0000;
        @(negedge clk);
        reset[0]  = 1'b0;
        strobe[0] = 1'b0;
        #1;
        check_reset_outputs(0);
        base = wr_cnt[0];
        repeat (3) send(0, 16'h1000);
        check("t6_no_write_after_reset", wr_cnt[0], base);
        check("t6_armed",                {31'd0, armed[0]}, 32'd1);
        send(0, 16'h8000);
        send_exp(0, 16'h0100, 9'h100, 8'h81);

        // 4: DECIMATE=4
        send(1, 16'h8000);
        send_exp(1, 16'h0200, 9'h100, 8'h82);
        for (int j = 1; j <= 12; j++) begin
            if (j % 4 == 0) send_exp(1, 16'h0200, {1'b1, 8'(j / 4)}, 8'h82);
            else            send(1, 16'h0200);
        end
        check("t4_write_count", wr_cnt[1], 4);

        // 5b: AUTO_TIMEOUT=0 never forces a trigger
        pulse_reset(1);
        base = wr_cnt[1];
        repeat (2000) send(1, 16'h4000);
        check("t5_no_auto_trigger", wr_cnt[1], base);
        check("t5_still_armed",     {31'd0, armed[1]}, 32'd1);

        // 5a: AUTO_TIMEOUT=16 forces a trigger on strobe 16
        for (int i = 1; i <= 15; i++) send(2, 16'h4000);
        check("t5_no_write_1_15", wr_cnt[2], 0);
        check("t5_armed_15",      {31'd0, armed[2]}, 32'd1);
        send_exp(2, 16'h4000, 9'h100, 8'hC0);
        check("t5_active", {30'd0, dbg[2]}, {30'd0, S_ACTIVE});

        repeat (3) @(negedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
